// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Decodes the opcode, sequences the datapath strobes over 3-5 cycles,
// counts retired instructions and flags unsupported opcodes.
// Optional feature macro: CTRL_STATE_SEG_EN adds the seg_state output,
// an active-low seven-segment rendering of the current state number.
module mips_multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
`ifdef CTRL_STATE_SEG_EN
  ,
  output logic [6:0]       seg_state
`endif
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB  = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH = 4'd8;
  localparam logic [STATE_W-1:0] S_JUMP   = 4'd9;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   instr_count_q;
  logic [CNT_W-1:0]   instr_count_d;
  logic               illegal_op_q;
  logic               illegal_op_d;
  logic               retire;

  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  // Next state; retire marks every completion edge back into FETCH
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    illegal_op_d  = illegal_op_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unsupported opcode: abandon without retiring
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        // Only lw/sw reach here; anything but sw is treated as a load
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_ALUWB;
      end
      S_ALUWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: begin
        // Unused encodings recover to FETCH without retiring
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      instr_count_d = instr_count_q + CNT_W'(1);
    end
  end

  // Datapath strobes decoded from the state; all forced low during reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;

    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          // PC+4 is written back in the same cycle the fetch completes
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o     = reset_n ? state_q : '0;
  assign instr_count = instr_count_q;
  assign illegal_op  = illegal_op_q;

`ifdef CTRL_STATE_SEG_EN
  // Active-low hex digit of the state (bit6 = a .. bit0 = g), blank in reset
  always_comb begin
    seg_state = 7'b1111111;
    if (reset_n) begin
      case (state_q)
        4'h0:    seg_state = 7'b0000001;
        4'h1:    seg_state = 7'b1001111;
        4'h2:    seg_state = 7'b0010010;
        4'h3:    seg_state = 7'b0000110;
        4'h4:    seg_state = 7'b1001100;
        4'h5:    seg_state = 7'b0100100;
        4'h6:    seg_state = 7'b0100000;
        4'h7:    seg_state = 7'b0001111;
        4'h8:    seg_state = 7'b0000000;
        4'h9:    seg_state = 7'b0000100;
        4'hA:    seg_state = 7'b0001000;
        4'hB:    seg_state = 7'b1100000;
        4'hC:    seg_state = 7'b0110001;
        4'hD:    seg_state = 7'b1000010;
        4'hE:    seg_state = 7'b0110000;
        default: seg_state = 7'b0111000;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed instruction
// sequences with literal expectations, then randomized traffic checked every
// cycle against a route-table model of the instruction flow.
module tb_mips_multicycle_control;

  // Narrow counter so the wrap-around case is reachable in a few thousand cycles
  localparam int unsigned TB_CNT_W = 10;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b001111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [5:0]          opcode = 6'd0;
  logic                mem_ready = 1'b0;
  logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic                IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0]          ALUSrcB, ALUOp, PCSource;
  logic [3:0]          state_o;
  logic [TB_CNT_W-1:0] instr_count;
  logic                illegal_op;
`ifdef CTRL_STATE_SEG_EN
  logic [6:0]          seg_state;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        chk_en = 1'b0;

  // Model: position within the current instruction's route, count, flag
  int                  m_step = 0;
  logic [TB_CNT_W-1:0] m_count = '0;
  logic                m_illegal = 1'b0;

  mips_multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state_o     (state_o),
    .instr_count (instr_count),
    .illegal_op  (illegal_op)
`ifdef CTRL_STATE_SEG_EN
    ,
    .seg_state   (seg_state)
`endif
  );

  always #5 clk = ~clk;

  // Sequence of state numbers each opcode walks through (nibble i = step i)
  function automatic logic [3:0] route_state(input logic [5:0] op, input int step);
    logic [19:0] r;
    case (op)
      OP_R:    r = 20'h07610;
      OP_LW:   r = 20'h43210;
      OP_SW:   r = 20'h05210;
      OP_BEQ:  r = 20'h00810;
      OP_J:    r = 20'h00910;
      default: r = 20'h00010;
    endcase
    return r[step*4 +: 4];
  endfunction

  function automatic int route_len(input logic [5:0] op);
    case (op)
      OP_R:    return 4;
      OP_LW:   return 5;
      OP_SW:   return 4;
      OP_BEQ:  return 3;
      OP_J:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  // FETCH, MEMRD and MEMWR are the only states that wait on memory
  function automatic logic waits_mem(input logic [3:0] s);
    return (s == 4'd0) || (s == 4'd3) || (s == 4'd5);
  endfunction

  // Strobe table per state number
  function automatic ctl_t exp_ctl(input logic [3:0] s, input logic mr);
    ctl_t c;
    c = '0;
    case (s)
      4'd0: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      4'd1: begin c.alu_src_b = 2'b11; end
      4'd2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3: begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4'd4: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      4'd5: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      4'd6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      4'd8: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      4'd9: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default: begin end
    endcase
    return c;
  endfunction

`ifdef CTRL_STATE_SEG_EN
  function automatic logic [6:0] exp_seg(input logic [3:0] s);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
          7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[s];
  endfunction
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advance on every rising edge
  always @(posedge clk) begin
    if (!reset_n) begin
      m_step    <= 0;
      m_count   <= '0;
      m_illegal <= 1'b0;
    end else if (!(waits_mem(route_state(opcode, m_step)) && !mem_ready)) begin
      if (m_step == route_len(opcode) - 1) begin
        m_step <= 0;
        if (is_legal(opcode)) m_count <= m_count + TB_CNT_W'(1);
        else                  m_illegal <= 1'b1;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      logic [3:0] s;
      ctl_t       e;
      ctl_t       a;
      s = reset_n ? route_state(opcode, m_step) : 4'd0;
      e = reset_n ? exp_ctl(s, mem_ready) : '0;
      a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
      check("state_o", 32'(state_o), 32'(s));
      check("strobes", 32'(a), 32'(e));
      check("instr_count", 32'(instr_count), 32'(m_count));
      check("illegal_op", 32'(illegal_op), 32'(m_illegal));
`ifdef CTRL_STATE_SEG_EN
      check("seg_state", 32'(seg_state), reset_n ? 32'(exp_seg(s)) : 32'h7f);
`endif
    end
  end

  // One clock: drive inputs just after the edge, return at the falling edge
  task automatic step(input logic rn, input logic [5:0] op, input logic mr);
    @(posedge clk);
    #1;
    reset_n   = rn;
    opcode    = op;
    mem_ready = mr;
    @(negedge clk);
  endtask

  // Run one instruction from FETCH with a mem_ready pattern and literal state list
  task automatic run_instr(input string nm, input logic [5:0] op, input int n,
                           input logic [63:0] seq, input logic [15:0] mr);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      step(1'b1, op, mr[i]);
      e = seq[i*4 +: 4];
      check({nm, "_state"}, 32'(state_o), 32'(e));
      case (e)
        4'd0: check({nm, "_irwrite"}, 32'(IRWrite), 32'(mr[i]));
        4'd3: check({nm, "_memrd"}, 32'({MemRead, IorD}), 32'h3);
        4'd4: check({nm, "_memtoreg"}, 32'({MemtoReg, RegWrite, RegDst}), 32'h6);
        4'd6: check({nm, "_aluop"}, 32'(ALUOp), 32'h2);
        4'd7: check({nm, "_aluwb"}, 32'({RegWrite, RegDst}), 32'h3);
        4'd8: check({nm, "_branch"}, 32'({ALUOp, PCWriteCond, PCSource}), 32'b01_1_01);
        4'd9: check({nm, "_jump"}, 32'({PCWrite, PCSource}), 32'b1_10);
        default: begin end
      endcase
`ifdef CTRL_STATE_SEG_EN
      if (e == 4'd0) check({nm, "_seg_fetch"}, 32'(seg_state), 32'b0000001);
      if (e == 4'd1) check({nm, "_seg_decode"}, 32'(seg_state), 32'b1001111);
`endif
    end
  endtask

  // Hold FETCH one cycle (mem_ready low) and check the retired count
  task automatic idle_count(input string nm, input logic [TB_CNT_W-1:0] exp);
    step(1'b1, opcode, 1'b0);
    check({nm, "_fetch"}, 32'(state_o), 32'h0);
    check({nm, "_count"}, 32'(instr_count), 32'(exp));
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 9))
      0, 1:    return OP_R;
      2, 3:    return OP_LW;
      4, 5:    return OP_SW;
      6:       return OP_BEQ;
      7:       return OP_J;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    // Reset
    step(1'b0, OP_R, 1'b1);
    chk_en = 1'b1;
    step(1'b0, OP_R, 1'b1);
    check("rst_state", 32'(state_o), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_illegal", 32'(illegal_op), 32'h0);
`ifdef CTRL_STATE_SEG_EN
    check("rst_seg_blank", 32'(seg_state), 32'h7f);
`endif

    // R-type, zero wait states: 0,1,6,7
    run_instr("rtype", OP_R, 4, 64'h7610, 16'hFFFF);
    idle_count("rtype", 10'd1);

    // lw with three MEMRD wait cycles: 0,1,2,3,3,3,3,4
    run_instr("lw_wait", OP_LW, 8, 64'h43333210, 16'h00C7);
    idle_count("lw_wait", 10'd2);

    run_instr("beq", OP_BEQ, 3, 64'h810, 16'hFFFF);
    idle_count("beq", 10'd3);
    run_instr("jump", OP_J, 3, 64'h910, 16'hFFFF);
    idle_count("jump", 10'd4);

    // Unsupported opcode: back to FETCH, sticky flag, not counted
    run_instr("illegal", OP_BAD, 2, 64'h10, 16'hFFFF);
    idle_count("illegal", 10'd4);
    check("illegal_set", 32'(illegal_op), 32'h1);
    for (int k = 0; k < 3; k++) begin
      run_instr("rtype_after_bad", OP_R, 4, 64'h7610, 16'hFFFF);
      idle_count("rtype_after_bad", TB_CNT_W'(5 + k));
      check("illegal_sticky", 32'(illegal_op), 32'h1);
    end

    // Reset while stalled in MEMWR abandons the store
    run_instr("sw_stall", OP_SW, 4, 64'h5210, 16'h0007);
    step(1'b0, OP_SW, 1'b0);
    check("rst_mid_state", 32'(state_o), 32'h0);
    check("rst_mid_strobes", 32'({MemWrite, IorD, MemRead, PCWrite, RegWrite}), 32'h0);
    step(1'b1, OP_SW, 1'b0);
    check("rst_mid_after_state", 32'(state_o), 32'h0);
    check("rst_mid_after_count", 32'(instr_count), 32'h0);
    check("rst_mid_after_illegal", 32'(illegal_op), 32'h0);

    // Counter wrap: fill to all ones, then one more instruction
    for (int k = 0; k < (1 << TB_CNT_W) - 1; k++) begin
      step(1'b1, OP_J, 1'b1);
      step(1'b1, OP_J, 1'b1);
      step(1'b1, OP_J, 1'b1);
    end
    idle_count("wrap_full", '1);
    run_instr("wrap_last", OP_J, 3, 64'h910, 16'hFFFF);
    idle_count("wrap_zero", '0);

    // Randomized traffic; opcode only changes while the model is in FETCH
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      reset_n   = ($urandom_range(0, 249) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (m_step == 0) opcode = pick_op();
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode and sequences datapath strobes over 3–5 cycles per instruction.
- Drives the 2-bit ALUOp consumed by the ALU control decoder.
- Also counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  PC write if ALU zero.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  destination register: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = A register.
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- ALUOp  output  2  to ALU control: 00 = add, 01 = subtract, 10 = R-type funct decode.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_o  output  4  current state number, for debug.
- instr_count  output  CNT_W  retired instructions.
- illegal_op  output  1  sticky flag: unsupported opcode decoded.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset: while reset_n = 0, every strobe and mux output is forced to 0. On the reset edge: state <= FETCH(0), instr_count <= 0, illegal_op <= 0.
- Reset mid-instruction abandons that instruction. It is not counted.
- State register is encoded 0–9. Outputs are decoded from the state; any output not listed for a state is 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- FETCH(0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Transition: stay while mem_ready=0; when mem_ready=1, go to DECODE.
- DECODE(1):
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Transition: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP.
  - Any other opcode: go to FETCH and set illegal_op=1; instr_count is not incremented.
- MEMADR(2):
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Transition: lw→MEMRD, sw→MEMWR.
- MEMRD(3):
  - Outputs: MemRead=1, IorD=1.
  - Transition: wait for mem_ready, then go to MEMWB.
- MEMWB(4):
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
  - Transition: go to FETCH.
- MEMWR(5):
  - Outputs: MemWrite=1, IorD=1.
  - Transition: wait for mem_ready, then go to FETCH.
- EXEC(6):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Transition: go to ALUWB.
- ALUWB(7):
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Transition: go to FETCH.
- BRANCH(8):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Transition: go to FETCH.
- JUMP(9):
  - Outputs: PCWrite=1, PCSource=10.
  - Transition: go to FETCH.
- Unused encodings 10–15: go to FETCH on the next edge; outputs are 0 while in them.
- Instruction cycle counts with zero wait states: lw 5, sw 4, R-type 4, beq 3, j 3.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP.
- instr_count wraps from 2^CNT_W−1 to 0 with no flag.
- opcode is sampled only in DECODE and MEMADR. The instruction register holds it stable for the whole instruction.

Optional Feature:
- Macro: CTRL_STATE_SEG_EN.
- Defined:
  - Adds output seg_state [6:0]: state_o as an active-low hex digit, bit6 = segment a … bit0 = segment g (0→7'b0000001, 1→7'b1001111, …).
  - seg_state is 7'b1111111 (blank) during reset.
- Undefined: the port and its decoder are absent. All other behaviour is identical.

Test Plan:
- Reset, then R-type with mem_ready tied 1: state sequence 0,1,6,7,0. ALUOp=10 in state 6, RegWrite=1 and RegDst=1 in state 7. instr_count=1.
- lw with mem_ready held 0 for 3 cycles in MEMRD: state 3 held 4 cycles with MemRead=1 and IorD=1. Then MEMWB with MemtoReg=1. Total 8 cycles; count increments.
- beq: ALUOp=01, PCWriteCond=1 and PCSource=01 in state 8 only. j: PCWrite=1 and PCSource=10 in state 9. Each takes 3 cycles.
- opcode 001111 in DECODE: next state 0, illegal_op=1 and stays set through 3 further R-types. instr_count is not incremented for the illegal opcode.
- reset_n=0 asserted in MEMWR: all outputs 0 that cycle, state 0 and instr_count 0 after the edge. Preload instr_count to 0xFFFF via 65535 j instructions, run one more: count=0.
- With CTRL_STATE_SEG_EN: seg_state=7'b0000001 in FETCH and 7'b1001111 in DECODE.
